// File: rtl/pipeline_stage_buffer.sv
// Parametrised inter-stage pipeline register: payload, valid and sticky side-band
// under shared-stall control, with saturating bubble and hold counters.
module pipeline_stage_buffer #(
  parameter int unsigned              PAYLOAD_WIDTH = 64,
  parameter int unsigned              STICKY_WIDTH  = 1,
  parameter int unsigned              STALL_WIDTH   = 6,
  parameter int unsigned              STAGE         = 2,
  parameter logic [PAYLOAD_WIDTH-1:0] BUBBLE_VALUE  = '0,
  parameter int unsigned              COUNT_WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [STALL_WIDTH-1:0]   stall,
  input  logic                     flush,
  input  logic                     clear_counters,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  input  logic                     in_valid,
  input  logic [STICKY_WIDTH-1:0]  in_sticky,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic                     out_valid,
  output logic [STICKY_WIDTH-1:0]  out_sticky,
  output logic [COUNT_WIDTH-1:0]   bubble_count,
  output logic [COUNT_WIDTH-1:0]   hold_count
);

  typedef enum logic [1:0] {
    ActAdvance,
    ActBubble,
    ActHold,
    ActFlush
  } action_e;

  logic                     up;
  logic                     dn;
  action_e                  action;

  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
  logic                     valid_q, valid_d;
  logic [STICKY_WIDTH-1:0]  sticky_q, sticky_d;
  logic [COUNT_WIDTH-1:0]   bubble_count_q, bubble_count_d;
  logic [COUNT_WIDTH-1:0]   hold_count_q, hold_count_d;

  // Only this stage's pair of stall bits matters; the rest of the vector is ignored.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];

  // up=0/dn=1 never comes from the stall controller and falls through to advance.
  always_comb begin
    action = ActAdvance;
    if (flush) begin
      action = ActFlush;
    end else if (up && !dn) begin
      action = ActBubble;
    end else if (up && dn) begin
      action = ActHold;
    end
  end

  always_comb begin
    payload_d = payload_q;
    valid_d   = valid_q;
    sticky_d  = sticky_q;
    unique case (action)
      ActFlush: begin
        payload_d = BUBBLE_VALUE;
        valid_d   = 1'b0;
        sticky_d  = '0;
      end
      ActBubble: begin
        // Sticky survives the bubble so the delay-slot flag is not lost.
        payload_d = BUBBLE_VALUE;
        valid_d   = 1'b0;
      end
      ActHold: begin
      end
      ActAdvance: begin
        payload_d = in_payload;
        valid_d   = in_valid;
        sticky_d  = in_sticky;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    bubble_count_d = bubble_count_q;
    hold_count_d   = hold_count_q;
    if (clear_counters) begin
      bubble_count_d = '0;
      hold_count_d   = '0;
    end else begin
      if (action == ActBubble && !(&bubble_count_q)) begin
        bubble_count_d = bubble_count_q + COUNT_WIDTH'(1);
      end
      if (action == ActHold && !(&hold_count_q)) begin
        hold_count_d = hold_count_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      payload_q      <= BUBBLE_VALUE;
      valid_q        <= 1'b0;
      sticky_q       <= '0;
      bubble_count_q <= '0;
      hold_count_q   <= '0;
    end else begin
      payload_q      <= payload_d;
      valid_q        <= valid_d;
      sticky_q       <= sticky_d;
      bubble_count_q <= bubble_count_d;
      hold_count_q   <= hold_count_d;
    end
  end

  assign out_payload  = payload_q;
  assign out_valid    = valid_q;
  assign out_sticky   = sticky_q;
  assign bubble_count = bubble_count_q;
  assign hold_count   = hold_count_q;

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Scoreboard bench for pipeline_stage_buffer: default instance, a 2-bit-counter
// instance for saturation, and a STAGE=0 / 8-bit / 0xFF-bubble instance.
module tb_pipeline_stage_buffer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Instance a: defaults.
  logic [5:0]  stall_a;
  logic        flush_a, clear_a, in_valid_a, out_valid_a;
  logic [63:0] in_payload_a, out_payload_a;
  logic [0:0]  in_sticky_a, out_sticky_a;
  logic [15:0] bubble_count_a, hold_count_a;

  // Instance b: COUNT_WIDTH=2.
  logic [5:0]  stall_b;
  logic        flush_b, clear_b, in_valid_b, out_valid_b;
  logic [63:0] in_payload_b, out_payload_b;
  logic [0:0]  in_sticky_b, out_sticky_b;
  logic [1:0]  bubble_count_b, hold_count_b;

  // Instance c: STAGE=0, PAYLOAD_WIDTH=8, BUBBLE_VALUE=0xFF.
  logic [5:0]  stall_c;
  logic        flush_c, clear_c, in_valid_c, out_valid_c;
  logic [7:0]  in_payload_c, out_payload_c;
  logic [0:0]  in_sticky_c, out_sticky_c;
  logic [15:0] bubble_count_c, hold_count_c;

  pipeline_stage_buffer u_dut_a (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall_a),
    .flush          (flush_a),
    .clear_counters (clear_a),
    .in_payload     (in_payload_a),
    .in_valid       (in_valid_a),
    .in_sticky      (in_sticky_a),
    .out_payload    (out_payload_a),
    .out_valid      (out_valid_a),
    .out_sticky     (out_sticky_a),
    .bubble_count   (bubble_count_a),
    .hold_count     (hold_count_a)
  );

  pipeline_stage_buffer #(
    .COUNT_WIDTH (2)
  ) u_dut_b (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall_b),
    .flush          (flush_b),
    .clear_counters (clear_b),
    .in_payload     (in_payload_b),
    .in_valid       (in_valid_b),
    .in_sticky      (in_sticky_b),
    .out_payload    (out_payload_b),
    .out_valid      (out_valid_b),
    .out_sticky     (out_sticky_b),
    .bubble_count   (bubble_count_b),
    .hold_count     (hold_count_b)
  );

  pipeline_stage_buffer #(
    .STAGE         (0),
    .PAYLOAD_WIDTH (8),
    .BUBBLE_VALUE  (8'hFF)
  ) u_dut_c (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall_c),
    .flush          (flush_c),
    .clear_counters (clear_c),
    .in_payload     (in_payload_c),
    .in_valid       (in_valid_c),
    .in_sticky      (in_sticky_c),
    .out_payload    (out_payload_c),
    .out_valid      (out_valid_c),
    .out_sticky     (out_sticky_c),
    .bubble_count   (bubble_count_c),
    .hold_count     (hold_count_c)
  );

  // A stall controller never asserts the downstream bit alone.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(!stall_a[2] && stall_a[3])) else $error("illegal stall pattern on a");
      assert (!(!stall_b[2] && stall_b[3])) else $error("illegal stall pattern on b");
      assert (!(!stall_c[0] && stall_c[1])) else $error("illegal stall pattern on c");
    end
  end

  typedef struct {
    int          dut;
    logic [63:0] payload;
    logic        valid;
    logic        sticky;
    logic [15:0] bcnt;
    logic [15:0] hcnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input int dut, input logic [63:0] p, input logic v, input logic s,
                          input logic [15:0] b, input logic [15:0] h);
    exp_t e;
    e.dut = dut; e.payload = p; e.valid = v; e.sticky = s; e.bcnt = b; e.hcnt = h;
    sb_q.push_back(e);
  endtask

  // Advance one clock and retire every expectation queued for this edge.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.dut)
        0: begin
          check_eq("a_payload", out_payload_a, e.payload);
          check_eq("a_valid", 64'(out_valid_a), 64'(e.valid));
          check_eq("a_sticky", 64'(out_sticky_a), 64'(e.sticky));
          check_eq("a_bubble_count", 64'(bubble_count_a), 64'(e.bcnt));
          check_eq("a_hold_count", 64'(hold_count_a), 64'(e.hcnt));
        end
        1: begin
          check_eq("b_payload", out_payload_b, e.payload);
          check_eq("b_valid", 64'(out_valid_b), 64'(e.valid));
          check_eq("b_sticky", 64'(out_sticky_b), 64'(e.sticky));
          check_eq("b_bubble_count", 64'(bubble_count_b), 64'(e.bcnt));
          check_eq("b_hold_count", 64'(hold_count_b), 64'(e.hcnt));
        end
        default: begin
          check_eq("c_payload", 64'(out_payload_c), e.payload);
          check_eq("c_valid", 64'(out_valid_c), 64'(e.valid));
          check_eq("c_sticky", 64'(out_sticky_c), 64'(e.sticky));
          check_eq("c_bubble_count", 64'(bubble_count_c), 64'(e.bcnt));
          check_eq("c_hold_count", 64'(hold_count_c), 64'(e.hcnt));
        end
      endcase
    end
  endtask

  task automatic drive_a(input logic [63:0] p, input logic v, input logic s,
                         input logic [5:0] st, input logic fl, input logic cl);
    in_payload_a = p; in_valid_a = v; in_sticky_a = s;
    stall_a = st; flush_a = fl; clear_a = cl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive_a(64'hDEADBEEF, 1'b1, 1'b1, 6'b0, 1'b0, 1'b0);
    stall_b = '0; flush_b = 0; clear_b = 0; in_payload_b = 64'hDEADBEEF; in_valid_b = 1;
    in_sticky_b = 1;
    stall_c = '0; flush_c = 0; clear_c = 0; in_payload_c = 8'h5A; in_valid_c = 1;
    in_sticky_c = 1;

    // Reset held two cycles with live input.
    for (int i = 0; i < 2; i++) begin
      exp_push(0, 64'h0, 0, 0, 0, 0);
      exp_push(1, 64'h0, 0, 0, 0, 0);
      exp_push(2, 64'hFF, 0, 0, 0, 0);
      tick();
    end
    reset = 1'b0;
    in_payload_b = '0; in_valid_b = 0; in_sticky_b = 0;
    in_payload_c = '0; in_valid_c = 0; in_sticky_c = 0;

    // Advance then hold three cycles with changing input.
    drive_a(64'h1234, 1, 1, 6'b000000, 0, 0); exp_push(0, 64'h1234, 1, 1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive_a(64'h9000 + 64'(i), 0, 0, 6'b001100, 0, 0);
      exp_push(0, 64'h1234, 1, 1, 0, 16'(i + 1));
      tick();
    end
    // Flush beats hold; counters untouched.
    drive_a(64'h7777, 1, 1, 6'b001100, 1, 0); exp_push(0, 64'h0, 0, 0, 0, 3); tick();

    // Advance 0x55 then bubble twice; sticky retained although input sticky is 0.
    drive_a(64'h55, 1, 1, 6'b000000, 0, 0); exp_push(0, 64'h55, 1, 1, 0, 3); tick();
    drive_a(64'h66, 1, 0, 6'b000111, 0, 0); exp_push(0, 64'h0, 0, 1, 1, 3); tick();
    exp_push(0, 64'h0, 0, 1, 2, 3); tick();

    // Bits outside STAGE/STAGE+1 ignored: this is an advance.
    drive_a(64'hAA, 1, 0, 6'b110011, 0, 0); exp_push(0, 64'hAA, 1, 0, 2, 3); tick();
    drive_a(64'hBB, 0, 1, 6'b000000, 0, 0); exp_push(0, 64'hBB, 0, 1, 2, 3); tick();
    // Clear wins over the hold increment.
    drive_a(64'hCC, 1, 0, 6'b001100, 0, 1); exp_push(0, 64'hBB, 0, 1, 0, 0); tick();
    drive_a(64'hCC, 1, 0, 6'b001100, 0, 0); exp_push(0, 64'hBB, 0, 1, 0, 1); tick();
    // Reset mid-hold wins, then hold resumes.
    reset = 1'b1; exp_push(0, 64'h0, 0, 0, 0, 0); tick();
    reset = 1'b0; exp_push(0, 64'h0, 0, 0, 0, 1); tick();
    // Flush during bubble pattern: no bubble count.
    drive_a(64'hDD, 1, 1, 6'b000111, 1, 0); exp_push(0, 64'h0, 0, 0, 0, 1); tick();
    drive_a(64'h0, 0, 0, 6'b000000, 0, 0);

    // Saturation with 2-bit counters.
    stall_b = 6'b000111;
    for (int i = 0; i < 5; i++) begin
      exp_push(1, 64'h0, 0, 0, (i < 3) ? 16'(i + 1) : 16'd3, 0);
      tick();
    end
    clear_b = 1; exp_push(1, 64'h0, 0, 0, 0, 0); tick();
    clear_b = 0; exp_push(1, 64'h0, 0, 0, 1, 0); tick();
    stall_b = 6'b001100;
    for (int i = 0; i < 4; i++) begin
      exp_push(1, 64'h0, 0, 0, 1, (i < 3) ? 16'(i + 1) : 16'd3);
      tick();
    end
    clear_b = 1; exp_push(1, 64'h0, 0, 0, 0, 0); tick();
    clear_b = 0; stall_b = '0;

    // STAGE=0 instance with 0xFF bubble value.
    in_payload_c = 8'h12; in_valid_c = 1; in_sticky_c = 1; stall_c = 6'b000000;
    exp_push(2, 64'h12, 1, 1, 0, 0); tick();
    stall_c = 6'b000001; in_sticky_c = 0;
    exp_push(2, 64'hFF, 0, 1, 1, 0); tick();
    stall_c = 6'b111100; in_payload_c = 8'h34; in_valid_c = 1; in_sticky_c = 0;
    exp_push(2, 64'h34, 1, 0, 1, 0); tick();
    stall_c = 6'b000011; in_payload_c = 8'h99;
    exp_push(2, 64'h34, 1, 0, 1, 1); tick();
    stall_c = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_buffer.md
# pipeline_stage_buffer

- Generic, parametrised inter-stage pipeline register for the MIPS CPU pipeline; successor to the fixed-width per-stage buffers.
- Carries a payload bus, a valid bit and a sticky side-band field between two stages under control of the shared stall vector.
- Handles bubble insertion, hold, flush and advance.
- Keeps saturating bubble and hold counters for pipeline performance analysis.
- One instance sits between each pair of adjacent stages; parameter `STAGE` selects which stall bits govern it.

## Interface

Parameters:
- `PAYLOAD_WIDTH`, 64: width of the stage payload bus.
- `STICKY_WIDTH`, 1: width of the side-band field (e.g. next-in-delay-slot flag). Updated only on advance; survives bubbles.
- `STALL_WIDTH`, 6: width of the shared stall vector.
- `STAGE`, 2: index of the upstream stage's stall bit. Legal range is 0..STALL_WIDTH-2. The downstream bit is `STAGE+1`.
- `BUBBLE_VALUE`, 0: payload value loaded on bubble, flush and reset.
- `COUNT_WIDTH`, 16: width of each performance counter.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in STALL_WIDTH: shared stall vector; bit set means that stage is stalled.
- `flush` in 1: active-high; kills the held instruction (exception/branch squash).
- `clear_counters` in 1: active-high synchronous clear of both counters.
- `in_payload` in PAYLOAD_WIDTH: payload from the upstream stage.
- `in_valid` in 1: upstream payload holds a real instruction.
- `in_sticky` in STICKY_WIDTH: side-band value from upstream.
- `out_payload` out PAYLOAD_WIDTH: registered payload to the downstream stage.
- `out_valid` out 1: registered valid.
- `out_sticky` out STICKY_WIDTH: registered side-band value.
- `bubble_count` out COUNT_WIDTH: number of bubble-insertion cycles, saturating.
- `hold_count` out COUNT_WIDTH: number of hold cycles, saturating.

## Operation

Signal shorthand:
- `up` = `stall[STAGE]`
- `dn` = `stall[STAGE+1]`

Register update, evaluated every rising edge. Exactly one action applies per cycle, in this priority order:
1. `reset`: `out_payload`=BUBBLE_VALUE, `out_valid`=0, `out_sticky`=0, both counters=0.
2. `flush`: `out_payload`=BUBBLE_VALUE, `out_valid`=0, `out_sticky`=0. Counters are unchanged.
3. Bubble (`up`=1, `dn`=0): `out_payload`=BUBBLE_VALUE, `out_valid`=0. `out_sticky` is retained, not cleared. `bubble_count` increments.
4. Hold (`up`=1, `dn`=1): all outputs retained. `hold_count` increments.
5. Advance (`up`=0): `out_payload`=`in_payload`, `out_valid`=`in_valid`, `out_sticky`=`in_sticky`.

Additional rules:
- `up`=0 with `dn`=1 is illegal; a stall controller never produces it. The block treats it as advance. The bench flags it with an assertion.
- Counters:
  - Each counter saturates at 2^COUNT_WIDTH-1 and never wraps.
  - `clear_counters` zeroes both counters. It takes priority over any increment in the same cycle and affects no other output.
  - Counters do not increment in a flush cycle, even if the stall bits would otherwise select bubble or hold.
- Bits of `stall` other than `STAGE` and `STAGE+1` are ignored.

## Timing

- Latency is 1 cycle from input to output on advance. The block has no combinational path from any input to any output.
- Reset values: `out_payload`=BUBBLE_VALUE, `out_valid`=0, `out_sticky`=0, `bubble_count`=0, `hold_count`=0. These are visible in the cycle after the reset edge.
- Reset asserted mid-hold or mid-bubble wins immediately. The next edge with `reset` low resumes normal priority.
- Flush asserted together with any stall combination: the flush result is taken; the stall does not hold the old payload.
- Hold keeps outputs bit-stable for any number of cycles; `out_valid` does not toggle.
- A bubble followed by further `up`=1, `dn`=0 cycles re-inserts the bubble every cycle, counting 1 per cycle. `out_sticky` stays constant throughout.
- A counter at its maximum value that is also cleared in the same cycle reads 0 on the next cycle.

## Test plan

- Reset: hold `reset`=1 for 2 cycles with `in_valid`=1 and `in_payload`=0xDEADBEEF -> all outputs 0 (BUBBLE_VALUE=0), both counters 0.
- Advance then hold:
  - Drive `in_payload`=0x1234, `in_valid`=1, `in_sticky`=1 with `stall`=0 -> next cycle `out_payload`=0x1234, `out_valid`=1, `out_sticky`=1.
  - Then set `stall`=6'b001100 (STAGE=2) for 3 cycles while changing `in_payload` -> outputs unchanged, `hold_count`=3.
- Bubble: after an advance of 0x55 with `out_sticky`=1, set `stall`=6'b000111 for 2 cycles -> `out_payload`=0, `out_valid`=0, `out_sticky`=1, `bubble_count`=2.
- Flush priority: `stall`=6'b001100 together with `flush`=1 while 0x1234 is held -> next cycle `out_payload`=0, `out_valid`=0, `out_sticky`=0, `hold_count` unchanged.
- Saturation: COUNT_WIDTH=2; 5 consecutive bubble cycles -> `bubble_count` reads 1, 2, 3, 3, 3. Then `clear_counters` during a bubble cycle -> 0.
- Parametrisation: STAGE=0, PAYLOAD_WIDTH=8, BUBBLE_VALUE=8'hFF:
  - `stall`=6'b000001 -> `out_payload`=0xFF.
  - `stall`=6'b111100 -> advance.
